valve_drive_scheduler: RTL
==========================

# valve_drive_scheduler

Per-valve drive sequencer between the serial-frame deserializer and the solenoid driver pins. Each valve being opened gets a high-voltage pull-in pulse of fixed length, then drops to low-voltage hold. A global cap on simultaneous pull-in pulses limits supply peak current; waiting valves receive pull-in slots round-robin. Sits in `valveboard_firmware` and drives `signal_high_voltage`/`signal_low_voltage` directly.

## Interface
- `CH_NUM`, 48: number of valve channels.
- `BOOST_CYCLES`, 20000: pull-in length in `sys_clk` cycles (1 ms at 20 MHz); legal range 1..65535.
- `MAX_BOOST`, 4: maximum channels in pull-in at once; legal range 1..`CH_NUM`.

Ports:
- `sys_clk` in, 1: system clock.
- `rst_n` in, 1: reset, asynchronous, active-low.
- `cmd_valid` in, 1: one-cycle strobe; `cmd_data` is valid in this cycle.
- `cmd_data` in, `CH_NUM`: decoded frame, LSB = channel 0. 1 = open, 0 = closed. Polarity is already un-inverted upstream.
- `signal_high_voltage` out, `CH_NUM`: pull-in drive per channel.
- `signal_low_voltage` out, `CH_NUM`: hold drive per channel.
- `boost_active_cnt` out, `$clog2(CH_NUM+1)`: number of channels currently in pull-in.

## Operation
- Each channel has four states: `OFF` (hv=0, lv=0), `WAIT` (0, 0), `BOOST` (1, 0), `HOLD` (0, 1). The hv and lv outputs are never both 1.
- On `cmd_valid`, each channel updates from its bit:
  - bit=1 while in `OFF`: go to `WAIT`.
  - bit=1 in any other state: no change. A repeated open never re-boosts.
  - bit=0: go to `OFF` from any state. A `BOOST` channel releases its slot immediately.
- Arbiter, evaluated every cycle:
  - If the registered `boost_active_cnt` < `MAX_BOOST` and at least one channel is in `WAIT`, grant exactly one.
  - The grant goes to the first `WAIT` channel at or after `rr_ptr`, searching upward with wrap from `CH_NUM-1` to 0.
  - The granted channel enters `BOOST` next cycle, and `rr_ptr` becomes grant+1 (mod `CH_NUM`).
- A `BOOST` counter loads `BOOST_CYCLES-1` on entry and decrements each cycle. At 0 the channel goes to `HOLD`, so hv is high for exactly `BOOST_CYCLES` cycles.
- `boost_active_cnt` next value = current + grant − completions − cleared-while-`BOOST`. It never exceeds `MAX_BOOST`.
- If `cmd_valid` clears the channel the arbiter selected in the same cycle, the clear wins. The grant is dropped for that cycle; no substitute is granted.

## Timing
- hv and lv are direct flop outputs, glitch-free.
- `cmd_valid` at edge T:
  - state `WAIT` from T+1.
  - earliest `BOOST` (hv=1) from T+2.
  - `HOLD` from T+2+`BOOST_CYCLES`.
- A close command at edge T gives hv=lv=0 from T+1.
- A slot freed at edge T is counted in T+1, and the next grant's `BOOST` starts at T+2.
- At most one new pull-in starts per cycle.
- Reset values: all outputs 0, all states `OFF`, counters 0, `rr_ptr`=0. Reset asserted mid-pulse clears outputs asynchronously, with no wait for a clock.

## Configuration
- `VALVE_BOOST_LIMIT_EN` defined: cap and round-robin arbiter behave as above.
- Undefined: no arbiter and `MAX_BOOST` is ignored. An opened channel goes `OFF`→`BOOST` directly, with hv=1 from T+1 and all channels in the same frame boosting together. `WAIT` is unreachable. `boost_active_cnt` still counts.

## Structure
- Package `valve_drive_pkg`: channel state enum and defaults for `CH_NUM`, `BOOST_CYCLES` and `MAX_BOOST`.
- Sub-module `valve_channel_fsm`, instantiated `CH_NUM` times by generate.
  - Contains the state, boost counter and hv/lv flops.
  - Inputs: set, clear, grant.
  - Outputs: wait, boost_done, in_boost.
- The round-robin arbiter and active counter live in the parent.

## Test plan
Bench parameters: `BOOST_CYCLES`=8, `MAX_BOOST`=2, macro defined unless stated.

1. `cmd_data`=0x000000000001 at T → ch0 hv=1 during T+2..T+9, then lv=1 from T+10; all other outputs stay 0.
2. `cmd_data`=0x800000010009 (ch0, 3, 16, 47) → `BOOST` starts at T+2 (ch0), T+3 (ch3), T+11 (ch16), T+12 (ch47). Never more than 2 hv bits are high; `boost_active_cnt` ≤ 2 throughout.
3. During test 2, a close of ch0 at T+5 → ch0 outputs 0 from T+6 and ch16 enters `BOOST` at T+7.
4. `rst_n` dropped mid-pulse between edges → all hv/lv 0 immediately. After release, `cmd_data`=0x1 behaves exactly as in test 1.
5. Resend 0x000000000001 while ch0 is in `HOLD` → no new hv pulse; lv stays 1.
6. Macro undefined, `cmd_data`=0x800000010009 → all four hv bits high at T+1..T+8, `boost_active_cnt`=4, `HOLD` from T+9.

Source files
------------

// File: rtl/valve_drive_pkg.sv
// Shared types and defaults for the valve drive scheduler and its per-channel sequencers.
package valve_drive_pkg;

  typedef enum logic [1:0] {
    CH_OFF   = 2'd0,
    CH_WAIT  = 2'd1,
    CH_BOOST = 2'd2,
    CH_HOLD  = 2'd3
  } ch_state_e;

  localparam int CH_NUM_DEFAULT       = 48;
  localparam int BOOST_CYCLES_DEFAULT = 20000;
  localparam int MAX_BOOST_DEFAULT    = 4;
  localparam int BOOST_CNT_W          = 16;

  // Index arithmetic for the round-robin search: (base + offset) mod modulus, offset < modulus.
  function automatic int wrap_add(input int base, input int offset, input int modulus);
    int sum;
    sum = base + offset;
    return (sum >= modulus) ? sum - modulus : sum;
  endfunction

endpackage

// File: rtl/valve_channel_fsm.sv
// One valve channel: OFF/WAIT/BOOST/HOLD sequencer with pull-in counter and registered hv/lv drives.
module valve_channel_fsm
  import valve_drive_pkg::*;
#(
  parameter int BOOST_CYCLES = BOOST_CYCLES_DEFAULT,
  parameter bit DIRECT_BOOST = 1'b0
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic set,
  input  logic clear,
  input  logic grant,
  output logic waiting,
  output logic boost_done,
  output logic in_boost,
  output logic hv,
  output logic lv
);

  localparam logic [BOOST_CNT_W-1:0] BOOST_LOAD = BOOST_CNT_W'(BOOST_CYCLES - 1);

  ch_state_e              state, state_nxt;
  logic [BOOST_CNT_W-1:0] boost_cnt, boost_cnt_nxt;

  always_comb begin
    state_nxt     = state;
    boost_cnt_nxt = boost_cnt;
    if (clear) begin
      state_nxt     = CH_OFF;
      boost_cnt_nxt = '0;
    end else begin
      case (state)
        CH_OFF: begin
          if (set) begin
            if (DIRECT_BOOST) begin
              state_nxt     = CH_BOOST;
              boost_cnt_nxt = BOOST_LOAD;
            end else begin
              state_nxt = CH_WAIT;
            end
          end
        end
        CH_WAIT: begin
          if (grant) begin
            state_nxt     = CH_BOOST;
            boost_cnt_nxt = BOOST_LOAD;
          end
        end
        CH_BOOST: begin
          if (boost_cnt == '0) begin
            state_nxt = CH_HOLD;
          end else begin
            boost_cnt_nxt = boost_cnt - BOOST_CNT_W'(1);
          end
        end
        CH_HOLD: state_nxt = CH_HOLD;
        default: state_nxt = CH_OFF;
      endcase
    end
  end

  // hv/lv are decoded from the next state so the pins come straight off flops.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CH_OFF;
      boost_cnt <= '0;
      hv        <= 1'b0;
      lv        <= 1'b0;
    end else begin
      state     <= state_nxt;
      boost_cnt <= boost_cnt_nxt;
      hv        <= (state_nxt == CH_BOOST);
      lv        <= (state_nxt == CH_HOLD);
    end
  end

  assign waiting    = (state == CH_WAIT);
  assign in_boost   = (state == CH_BOOST);
  assign boost_done = in_boost && (boost_cnt == '0) && !clear;

endmodule

// File: rtl/valve_drive_scheduler.sv
// Valve pull-in/hold scheduler with a global pull-in cap and round-robin slot arbiter.
// Define VALVE_BOOST_LIMIT_EN to enable the cap/arbiter; otherwise opened valves boost at once.
module valve_drive_scheduler
  import valve_drive_pkg::*;
#(
  parameter int CH_NUM       = CH_NUM_DEFAULT,
  parameter int BOOST_CYCLES = BOOST_CYCLES_DEFAULT,
  parameter int MAX_BOOST    = MAX_BOOST_DEFAULT
) (
  input  logic                         sys_clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  input  logic [CH_NUM-1:0]            cmd_data,
  output logic [CH_NUM-1:0]            signal_high_voltage,
  output logic [CH_NUM-1:0]            signal_low_voltage,
  output logic [$clog2(CH_NUM+1)-1:0]  boost_active_cnt
);

  localparam int CNT_W = $clog2(CH_NUM + 1);

  if (CH_NUM < 2 || BOOST_CYCLES < 1 || BOOST_CYCLES > 65535 ||
      MAX_BOOST < 1 || MAX_BOOST > CH_NUM) begin : g_param_check
    $error("valve_drive_scheduler: parameter out of legal range");
  end

  logic [CH_NUM-1:0] ch_set, ch_clear, ch_grant;
  logic [CH_NUM-1:0] ch_wait, ch_done, ch_boost;
  logic [CH_NUM-1:0] start_vec;
  logic [CNT_W-1:0]  cnt_nxt;

  assign ch_set   = {CH_NUM{cmd_valid}} & cmd_data;
  assign ch_clear = {CH_NUM{cmd_valid}} & ~cmd_data;

`ifdef VALVE_BOOST_LIMIT_EN
  localparam bit DIRECT_BOOST = 1'b0;
  localparam int PTR_W        = $clog2(CH_NUM);

  logic [PTR_W-1:0] rr_ptr, grant_idx, cand;
  logic             grant_found, grant_ok;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      cand = PTR_W'(wrap_add(int'(rr_ptr), i, CH_NUM));
      if (!grant_found && ch_wait[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // A clear landing on the selected channel cancels this cycle's grant outright.
  assign grant_ok = grant_found && (boost_active_cnt < CNT_W'(MAX_BOOST)) && !ch_clear[grant_idx];

  always_comb begin
    ch_grant = '0;
    if (grant_ok) begin
      ch_grant[grant_idx] = 1'b1;
    end
  end

  assign start_vec = ch_grant;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant_ok) begin
      rr_ptr <= (int'(grant_idx) == CH_NUM - 1) ? '0 : grant_idx + PTR_W'(1);
    end
  end
`else
  localparam bit DIRECT_BOOST = 1'b1;

  assign ch_grant  = '0;
  // Channels in OFF (not waiting, boosting or holding) start pull-in directly on open.
  assign start_vec = ch_set & ~(ch_wait | ch_boost | signal_low_voltage);
`endif

  assign cnt_nxt = CNT_W'(int'(boost_active_cnt) + $countones(start_vec)
                          - $countones(ch_done | (ch_boost & ch_clear)));

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      boost_active_cnt <= '0;
    end else begin
      boost_active_cnt <= cnt_nxt;
    end
  end

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    valve_channel_fsm #(
      .BOOST_CYCLES (BOOST_CYCLES),
      .DIRECT_BOOST (DIRECT_BOOST)
    ) u_ch (
      .sys_clk    (sys_clk),
      .rst_n      (rst_n),
      .set        (ch_set[i]),
      .clear      (ch_clear[i]),
      .grant      (ch_grant[i]),
      .waiting    (ch_wait[i]),
      .boost_done (ch_done[i]),
      .in_boost   (ch_boost[i]),
      .hv         (signal_high_voltage[i]),
      .lv         (signal_low_voltage[i])
    );
  end

endmodule
